drive_mult_seq: RTL and testbench

Multi-cycle sequencer for the desired-drive assist computation. It shares one 27x9 unsigned multiplier across the three products torque_pos*incline_lim*cadence_factor*scale, replacing the flat four-input multiply with a start/done handshake. It sits between the sensor/torque-averaging logic and the PID/brushless current loop, and produces a registered target_curr once per request.

---
 rtl/drive_mult_seq.sv | 185 ++++++++++++++++++
 tb/tb_drive_mult_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_mult_seq.sv
// Desired-drive assist sequencer: one shared 27x9 multiplier forms
// torque_pos*incline_lim*cadence_factor*scale over three cycles, then saturates.
module drive_mult_seq #(
    parameter logic [11:0] TORQUE_MIN  = 12'h380,
    parameter int          INCLINE_OFF = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] avg_torque,
    input  logic [4:0]  cadence,
    input  logic        not_pedaling,
    input  logic [12:0] incline,
    input  logic [2:0]  scale,
    output logic [11:0] target_curr,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        MUL2 = 3'd2,
        MUL3 = 3'd3,
        SAT  = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [11:0] torque_pos_r, torque_pos_s;
    logic [8:0]  incline_lim_r, incline_lim_s;
    logic [5:0]  cadence_factor_r, cadence_factor_s;
    logic [2:0]  scale_r;
    logic        np_r;
    logic [29:0] prod_r, mul_prod_s;
    logic [26:0] mul_a_s;
    logic [8:0]  mul_b_s;
    logic [11:0] target_curr_r;
    logic        done_r, busy_r;
    logic signed [9:0]  incline_sat_s;
    logic signed [10:0] incline_factor_s;

    // Equivalent of the incline_sat block: clamp the 13b signed incline to 10b.
    function automatic logic signed [9:0] incline_sat(input logic signed [12:0] v);
        logic signed [9:0] r;
        if (v > 13'sd511) begin
            r = 10'sd511;
        end else if (v < -13'sd512) begin
            r = -10'sd512;
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

    // Operand conditioning applied at the accepting edge.
    always_comb begin
        torque_pos_s     = 12'd0;
        incline_lim_s    = 9'd0;
        cadence_factor_s = 6'd0;
        incline_sat_s    = incline_sat($signed(incline));
        incline_factor_s = $signed({incline_sat_s[9], incline_sat_s}) + $signed(11'(INCLINE_OFF));
        if (avg_torque >= TORQUE_MIN) begin
            torque_pos_s = avg_torque - TORQUE_MIN;
        end else begin
            torque_pos_s = 12'd0;
        end
        if (incline_factor_s[10]) begin
            incline_lim_s = 9'd0;
        end else if (incline_factor_s > 11'sd511) begin
            incline_lim_s = 9'd511;
        end else begin
            incline_lim_s = incline_factor_s[8:0];
        end
        if (cadence >= 5'd2) begin
            cadence_factor_s = {1'b0, cadence} + 6'd32;
        end else begin
            cadence_factor_s = 6'd0;
        end
    end

    // Shared multiplier operand select; the running product feeds back as A.
    always_comb begin
        mul_a_s = 27'd0;
        mul_b_s = 9'd0;
        case (state_r)
            MUL1: begin
                mul_a_s = {15'd0, torque_pos_r};
                mul_b_s = incline_lim_r;
            end
            MUL2: begin
                mul_a_s = prod_r[26:0];
                mul_b_s = {3'd0, cadence_factor_r};
            end
            MUL3: begin
                mul_a_s = prod_r[26:0];
                mul_b_s = {6'd0, scale_r};
            end
            default: begin
                mul_a_s = 27'd0;
                mul_b_s = 9'd0;
            end
        endcase
        mul_prod_s = 30'(mul_a_s) * 30'(mul_b_s);
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = MUL1;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL1:    state_s = MUL2;
            MUL2:    state_s = MUL3;
            MUL3:    state_s = SAT;
            SAT:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Operand capture on the accepting edge; held for the rest of the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            torque_pos_r     <= 12'd0;
            incline_lim_r    <= 9'd0;
            cadence_factor_r <= 6'd0;
            scale_r          <= 3'd0;
            np_r             <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            torque_pos_r     <= torque_pos_s;
            incline_lim_r    <= incline_lim_s;
            cadence_factor_r <= cadence_factor_s;
            scale_r          <= scale;
            np_r             <= not_pedaling;
        end
    end

    // Product register, written in each multiply state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= 30'd0;
        end else if ((state_r == MUL1) || (state_r == MUL2) || (state_r == MUL3)) begin
            prod_r <= mul_prod_s;
        end
    end

    // Result register and done pulse; anything at or above 2^27 saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_curr_r <= 12'd0;
            done_r        <= 1'b0;
        end else begin
            done_r <= (state_r == SAT);
            if (state_r == SAT) begin
                if (np_r) begin
                    target_curr_r <= 12'd0;
                end else if (prod_r[29:27] != 3'd0) begin
                    target_curr_r <= 12'hFFF;
                end else begin
                    target_curr_r <= prod_r[26:15];
                end
            end
        end
    end

    assign target_curr = target_curr_r;
    assign done        = done_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_drive_mult_seq.sv
// Self-checking bench for drive_mult_seq: cycle-level behavioural model plus
// directed cases and randomized requests.
module tb_drive_mult_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic [11:0] target_curr;
    logic        done;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    drive_mult_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .incline      (incline),
        .scale        (scale),
        .target_curr  (target_curr),
        .done         (done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result from plain arithmetic on the rider inputs.
    function automatic int model_curr(input logic [11:0] a, input logic [4:0] c,
                                      input logic np, input logic [12:0] inc,
                                      input logic [2:0] s);
        int     tp, iv, fac, il, cf;
        longint p;
        tp  = (a >= 12'h380) ? int'(a) - 896 : 0;
        iv  = int'($signed(inc));
        if (iv > 511)  iv = 511;
        if (iv < -512) iv = -512;
        fac = iv + 256;
        il  = (fac < 0) ? 0 : ((fac > 511) ? 511 : fac);
        cf  = (c >= 5'd2) ? int'(c) + 32 : 0;
        p   = longint'(tp) * il * cf * s;
        if (np) return 0;
        if ((p >> 15) > 4095) return 4095;
        return int'(p >> 15);
    endfunction

    // Model: a request taken in idle delivers its result 4 edges later.
    int          m_cnt    = 0;
    int          m_result = 0;
    logic [11:0] m_target = 12'd0;
    logic        m_done   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_target <= 12'd0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_target <= 12'(m_result);
                    m_done   <= 1'b1;
                end
            end else if (start) begin
                m_result <= model_curr(avg_torque, cadence, not_pedaling, incline, scale);
                m_cnt    <= 4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        n_vec++;
        if (done !== m_done || busy !== (m_cnt != 0) || target_curr !== m_target) begin
            n_err++;
            $display("FAIL cycle t=%0t: done=%b busy=%b target_curr=%h, required done=%b busy=%b target_curr=%h",
                     $time, done, busy, target_curr, m_done, (m_cnt != 0), m_target);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called right after a negedge: issue one start pulse and return at done.
    task automatic request(input logic [11:0] a, input logic [12:0] inc, input logic [4:0] c,
                           input logic [2:0] s, input logic np, output int lat);
        avg_torque   = a;
        incline      = inc;
        cadence      = c;
        scale        = s;
        not_pedaling = np;
        start        = 1'b1;
        lat          = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    int          lat;
    int          ndone;
    logic [11:0] held;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        avg_torque   = 12'd0;
        cadence      = 5'd0;
        not_pedaling = 1'b0;
        incline      = 13'd0;
        scale        = 3'd0;

        check("model_nominal", model_curr(12'h700, 5'd16, 1'b0, 13'd0, 3'd3), 1008);
        check("model_sat", model_curr(12'hFFF, 5'd31, 1'b0, 13'd255, 3'd7), 4095);

        #12;
        check("reset_target", int'(target_curr), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        request(12'h700, 13'd0, 5'd16, 3'd3, 1'b0, lat);
        check("nominal_latency", lat, 5);
        check("nominal_value", int'(target_curr), 12'h3F0);

        request(12'hFFF, 13'd255, 5'd31, 3'd7, 1'b0, lat);
        check("sat_value", int'(target_curr), 12'hFFF);
        request(12'h700, 13'd0, 5'd16, 3'd3, 1'b0, lat);
        request(12'hFFF, 13'h0FFF, 5'd31, 3'd7, 1'b0, lat);
        check("sat_incline_0fff", int'(target_curr), 12'hFFF);

        request(12'h700, 13'd0, 5'd16, 3'd3, 1'b0, lat);
        request(12'h300, 13'd0, 5'd16, 3'd3, 1'b0, lat);
        check("zero_torque", int'(target_curr), 0);
        check("zero_torque_latency", lat, 5);
        request(12'h700, 13'h1ED4, 5'd16, 3'd3, 1'b0, lat);
        check("zero_incline", int'(target_curr), 0);
        request(12'h700, 13'd0, 5'd1, 3'd3, 1'b0, lat);
        check("zero_cadence", int'(target_curr), 0);
        request(12'h700, 13'd0, 5'd16, 3'd0, 1'b0, lat);
        check("zero_scale", int'(target_curr), 0);
        request(12'h700, 13'd0, 5'd16, 3'd3, 1'b1, lat);
        check("not_pedaling", int'(target_curr), 0);
        check("not_pedaling_latency", lat, 5);

        // Start held high: one accept per 5 cycles.
        start = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        check("held_start_dones", ndone, 4);
        repeat (6) @(negedge clk);

        // Operand change during MUL2 must not reach the in-flight result.
        request(12'h300, 13'd0, 5'd16, 3'd3, 1'b0, lat);
        avg_torque = 12'h700;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        avg_torque = 12'h380;
        lat = 0;
        for (int k = 3; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("inflight_latency", lat, 5);
        check("inflight_value", int'(target_curr), 12'h3F0);

        // Reset during MUL2 after a prior 0x3F0 result.
        avg_torque = 12'h700;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_target", int'(target_curr), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset_no_result", int'(target_curr), 0);
        request(12'h700, 13'd0, 5'd16, 3'd3, 1'b0, lat);
        check("after_reset_latency", lat, 5);
        check("after_reset_value", int'(target_curr), 12'h3F0);

        // Hold between requests.
        held = target_curr;
        repeat (20) @(negedge clk);
        check("hold_target", int'(target_curr), int'(held));
        check("hold_busy", int'(busy), 0);

        // Randomized traffic with input churn while busy.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start        = ($urandom_range(0, 2) == 0);
            avg_torque   = 12'($urandom);
            cadence      = 5'($urandom);
            incline      = 13'($urandom);
            scale        = 3'($urandom);
            not_pedaling = ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
